// File: rtl/btn_debounce_if.sv
// Button debouncer signal bundle: raw active-low button in, debounced
// level and event pulses out. The debouncer is the slave, the user the master.
interface btn_debounce_if;
  logic btn_n_i;
  logic btn_o;
  logic press_o;
  logic release_o;
  logic long_o;

  modport master (output btn_n_i, input btn_o, press_o, release_o, long_o);
  modport slave  (input btn_n_i, output btn_o, press_o, release_o, long_o);
endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop synchronizer, four-state debounce FSM,
// registered press/release pulses and an optional long-press pulse.
// Optional feature macro: BTN_LONG_PRESS_EN (adds the hold counter and long_o;
// without it long_o is tied low and LONG_PRESS_CYCLES is unused).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input logic           clk_i,
  input logic           rst_ni,
  btn_debounce_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_e;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          s1_q, s2_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q, btn_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  // Bring the raw button into the clock domain, inverted to active-high.
  // NOTE: sequential state always uses non-blocking (<=) so every flop
  // samples the pre-edge value of its source, giving a true 2-stage pipe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= ~bus.btn_n_i;
      s2_q <= s1_q;
    end
  end

  // Next-state logic: count consecutive stable samples before changing level.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          if (CNT_MAX == CNT_ONE) begin
            state_d = HELD;
            cnt_d   = '0;
            btn_d   = 1'b1;
            press_d = 1'b1;
          end else begin
            state_d = PRESS_CHK;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_CHK: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q + CNT_ONE == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          btn_d   = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s2_q) begin
          if (CNT_MAX == CNT_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
            btn_d   = 1'b0;
            rel_d   = 1'b1;
          end else begin
            state_d = REL_CHK;
            cnt_d   = CNT_ONE;
          end
        end
      end
      REL_CHK: begin
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q + CNT_ONE == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          btn_d   = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        btn_d   = 1'b0;
      end
    endcase
  end

  // FSM register: state, counter and all outputs come straight from flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign bus.btn_o     = btn_q;
  assign bus.press_o   = press_q;
  assign bus.release_o = rel_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Count cycles spent in HELD since the accepted press; frozen in REL_CHK
  // so a release bounce does not restart it, saturating at the threshold.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if (state_q == HELD && hold_q != HOLD_MAX && !rel_d) begin
      hold_d = hold_q + HOLD_ONE;
      long_d = (hold_q + HOLD_ONE == HOLD_MAX);
    end
  end

  // Hold counter and long-press pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign bus.long_o = long_q;
`else
  assign bus.long_o = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10):
// directed latency/bounce/long/reset scenarios followed by random button
// activity, all compared against a run-length reference model.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic rst_n;

  btn_debounce_if bus ();

  btn_debounce #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: a two-sample delay line, the accepted level, and the
  // length of the current run of samples that disagree with that level.
  bit m_p0, m_p1;
  bit m_lvl;
  int m_run;
  int m_held;
  bit e_press, e_rel, e_long;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p0 = 0; m_p1 = 0; m_lvl = 0; m_run = 0; m_held = 0;
    e_press = 0; e_rel = 0; e_long = 0;
  endtask

  // One rising edge with raw input b. The level flips once D consecutive
  // synchronized samples disagree with it; long fires after L cycles spent
  // pressed with no pending release run.
  task automatic model_edge(input bit b);
    bit smp;
    smp  = m_p1;
    m_p1 = m_p0;
    m_p0 = ~b;
    e_press = 0; e_rel = 0; e_long = 0;
`ifdef BTN_LONG_PRESS_EN
    if (m_lvl && m_run == 0 && m_held < L) begin
      m_held++;
      if (m_held == L) e_long = 1;
    end
`endif
    if (smp != m_lvl) begin
      m_run++;
      if (m_run == D) begin
        m_lvl = smp;
        m_run = 0;
        if (smp) begin
          e_press = 1;
          m_held  = 0;
        end else begin
          e_rel = 1;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".btn"},     bus.btn_o,     m_lvl);
    check({tag, ".press"},   bus.press_o,   e_press);
    check({tag, ".release"}, bus.release_o, e_rel);
    check({tag, ".long"},    bus.long_o,    e_long);
  endtask

  // Drive one input value for one clock, then check against the model
  // on the falling edge.
  task automatic step(input bit b);
    bus.btn_n_i = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    check_all("step");
  endtask

  // One-cycle reset pulse starting at a falling edge; outputs must clear
  // asynchronously, before any clock edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    check_all("in_rst");
    rst_n = 1'b1;
  endtask

  initial begin
    int press_at, rel_at, long_at, n_p, n_r, n_l;
    bit btn_stayed;
    int len;
    bit v;

    rst_n = 1'b0;
    bus.btn_n_i = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b1);

    // Clean press: press at edge D+2 = 6, then keep holding for long press.
    press_at = 0; long_at = 0; n_p = 0; n_r = 0; n_l = 0;
    for (int i = 1; i <= 26; i++) begin
      step(1'b0);
      if (bus.press_o) begin n_p++; if (press_at == 0) press_at = i; end
      if (bus.release_o) n_r++;
      if (bus.long_o) begin n_l++; if (long_at == 0) long_at = i; end
    end
    check("clean_press_edge", press_at, 6);
    check("clean_press_count", n_p, 1);
    check("clean_no_release", n_r, 0);
`ifdef BTN_LONG_PRESS_EN
    check("long_edge", long_at, 16);
    check("long_count", n_l, 1);
`else
    check("long_count", n_l, 0);
`endif

    // Release bounce: high 2, low 1, then high held.
    btn_stayed = 1;
    step(1'b1); if (!bus.btn_o) btn_stayed = 0;
    step(1'b1); if (!bus.btn_o) btn_stayed = 0;
    step(1'b0); if (!bus.btn_o) btn_stayed = 0;
    rel_at = 0; n_r = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1);
      if (bus.release_o) begin n_r++; if (rel_at == 0) rel_at = i; end
      if (rel_at == 0 && !bus.btn_o) btn_stayed = 0;
    end
    check("rel_bounce_btn_held", btn_stayed, 1);
    check("rel_bounce_edge", rel_at, 6);
    check("rel_bounce_count", n_r, 1);
    repeat (3) step(1'b1);

    // Press bounce: low 3, high 1, then low held.
    n_p = 0;
    repeat (3) begin step(1'b0); if (bus.press_o) n_p++; end
    step(1'b1); if (bus.press_o) n_p++;
    press_at = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0);
      if (bus.press_o) begin n_p++; if (press_at == 0) press_at = i; end
    end
    check("bounce_press_edge", press_at, 6);
    check("bounce_press_count", n_p, 1);

    // Reset while HELD and the button is still down.
    check("pre_rst_btn", bus.btn_o, 1);
    pulse_reset();
    press_at = 0; n_r = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0);
      if (bus.press_o && press_at == 0) press_at = i;
      if (bus.release_o) n_r++;
    end
    check("post_rst_press_edge", press_at, 6);
    check("post_rst_no_release", n_r, 0);

    // Random button activity with occasional resets.
    for (int seg = 0; seg < 150; seg++) begin
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 16) : $urandom_range(1, 6);
      repeat (len) step(v);
      if (seg % 50 == 49) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the number of consecutive stable synchronized samples needed to accept a press or release; legal range is 1 or greater.
REQ-002 Parameter LONG_PRESS_CYCLES, default 50000000, SHALL set the number of cycles in HELD before long_o fires; legal range is 1 or greater.
REQ-003 clk_i  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 btn_n_i  input  1  SHALL be the raw, asynchronous, bouncing push-button; active-low (0 = pressed).
REQ-006 btn_o  output  1  SHALL be the debounced button level; active-high (1 = pressed).
REQ-007 press_o  output  1  SHALL be a one-cycle pulse for each accepted press.
REQ-008 release_o  output  1  SHALL be a one-cycle pulse for each accepted release.
REQ-009 long_o  output  1  SHALL be a one-cycle pulse when a press has been held LONG_PRESS_CYCLES cycles.

Function
REQ-010 btn_n_i SHALL be inverted and passed through a 2-flop synchronizer (s1, s2) before any other use; s2 is the only signal the FSM reads.
REQ-011 The FSM SHALL have exactly four states: IDLE, PRESS_CHK, HELD, REL_CHK; reset state is IDLE.
REQ-012 IDLE: s2=1 SHALL move to PRESS_CHK with the counter set to 1; otherwise stay.
REQ-013 PRESS_CHK: s2=0 SHALL return to IDLE (bounce rejected, counter cleared, no pulse); s2=1 SHALL increment the counter.
REQ-014 PRESS_CHK: when the counter reaches DEBOUNCE_CYCLES, the FSM SHALL move to HELD, set btn_o=1 and pulse press_o on that same edge.
REQ-015 With DEBOUNCE_CYCLES=1, the FSM SHALL go IDLE->HELD directly on the first s2=1 sample.
REQ-016 Press latency: for a clean input, btn_o and press_o SHALL rise immediately after rising edge number DEBOUNCE_CYCLES+2, counting the first edge that samples btn_n_i=0 as edge 1.
REQ-017 HELD: s2=0 SHALL move to REL_CHK with the counter set to 1; btn_o SHALL stay 1.
REQ-018 REL_CHK: s2=1 SHALL return to HELD with no pulse; s2=0 SHALL increment the counter.
REQ-019 REL_CHK: at DEBOUNCE_CYCLES, the FSM SHALL move to IDLE, clear btn_o and pulse release_o; release latency equals the press latency.
REQ-020 press_o, release_o and long_o SHALL be registered, high for exactly one cycle, and mutually exclusive.
REQ-021 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits, SHALL never wrap, and SHALL be cleared on every state change that does not set it to 1.
REQ-022 Any input pulse shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no output change.
REQ-023 btn_o SHALL be driven directly from a flop (glitch-free), suitable for direct use by a downstream edge-detecting counter.

Reset
REQ-024 rst_ni=0 SHALL immediately force s1=s2=0, state IDLE, counters 0, and btn_o, press_o, release_o, long_o all 0, regardless of clk_i.
REQ-025 Reset asserted mid-press SHALL discard the press with no release_o pulse; a button still held after reset release SHALL be accepted as a new press with full REQ-016 latency.

Configuration
REQ-026 With macro BTN_LONG_PRESS_EN defined, the block SHALL include a hold counter of $clog2(LONG_PRESS_CYCLES+1) bits, cleared on entry to HELD and held, not cleared, in REL_CHK.
REQ-027 With BTN_LONG_PRESS_EN defined, the block SHALL pulse long_o once per press when the hold count reaches LONG_PRESS_CYCLES; the count then saturates with no further pulse until the next accepted press.
REQ-028 Without BTN_LONG_PRESS_EN, the long_o port SHALL remain present and tied to 0, the hold counter SHALL not exist, and LONG_PRESS_CYCLES SHALL be ignored.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10)
REQ-029 Clean press: btn_n_i 1->0 and held -> btn_o=1 and a press_o pulse immediately after edge 6; no other pulses.
REQ-030 Bounce: btn_n_i low for 3 cycles, high 1 cycle, then low and held -> no pulse during the bounce; press_o only after 4 consecutive s2=1 samples following the last bounce.
REQ-031 Release bounce: from HELD, btn_n_i high 2 cycles, low 1 cycle, then high and held -> btn_o stays 1 through the bounce; a single release_o 4 samples after the last bounce.
REQ-032 Long press (macro defined): button held 20 cycles after press_o -> exactly one long_o pulse, 10 cycles after press_o; with the macro undefined, long_o stays 0 throughout.
REQ-033 Reset mid-operation: rst_ni low for 1 cycle while in HELD with the button held -> all outputs 0 at once with no release_o; press_o again after edge 6 following reset release.
